// File: rtl/write_back_unit.sv
// Write-back stage: a two-entry result buffer drains into the register-file
// write port, and a per-register pending-write scoreboard lets operand fetch
// stall on read-after-write hazards.
module write_back_unit #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int PC_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_reg,
    output logic                issue_full,
    input  logic [ADDR_W-1:0]   src1_addr,
    input  logic [ADDR_W-1:0]   src2_addr,
    output logic                hazard_stall,
    output logic [NUM_REGS-1:0] busy_mask,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_sel,
    input  logic                in_reg_write,
    input  logic [ADDR_W-1:0]   in_dest,
    input  logic [DATA_W-1:0]   in_alu,
    input  logic [DATA_W-1:0]   in_mem,
    input  logic [PC_W-1:0]     in_pc,
    input  logic                rf_hold,
    output logic                rf_write_en,
    output logic [ADDR_W-1:0]   rf_write_addr,
    output logic [DATA_W-1:0]   rf_write_data
);

    // The source mux is applied on entry, so the buffer only carries final data.
    logic [DATA_W-1:0] data_mem [0:1];
    logic [ADDR_W-1:0] dest_mem [0:1];
    logic              rw_mem   [0:1];

    logic [1:0]        count_reg;
    logic [1:0]        count_next;
    logic              rd_ptr_reg;
    logic              wr_ptr_reg;
    logic              in_ready_reg;
    logic              rf_write_en_reg;
    logic [ADDR_W-1:0] rf_write_addr_reg;
    logic [DATA_W-1:0] rf_write_data_reg;
    logic [1:0]        pending_reg [NUM_REGS];

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] sel_data;

    assign push = in_valid & in_ready_reg;
    assign pop  = (count_reg != 2'd0) & ~rf_hold;

    // Select the write-back source; PC link values are zero-extended.
    always_comb begin
        sel_data = in_alu;
        case (in_sel)
            2'b01:   sel_data = in_mem;
            2'b10:   sel_data = {{(DATA_W-PC_W){1'b0}}, in_pc};
            default: sel_data = in_alu;
        endcase
    end

    // Occupancy after this edge; simultaneous push and pop cancel out.
    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + 2'd1;
        else if (pop && !push)
            count_next = count_reg - 2'd1;
    end

    // Buffer storage: plain array written at the tail, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= sel_data;
            dest_mem[wr_ptr_reg] <= in_dest;
            rw_mem[wr_ptr_reg]   <= in_reg_write;
        end
    end

    // Buffer pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            in_ready_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            in_ready_reg <= (count_next < 2'd2);
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // Register-file write port: loaded on pop, address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_en_reg   <= 1'b0;
            rf_write_addr_reg <= '0;
            rf_write_data_reg <= '0;
        end else if (pop) begin
            rf_write_en_reg   <= rw_mem[rd_ptr_reg];
            rf_write_addr_reg <= dest_mem[rd_ptr_reg];
            rf_write_data_reg <= data_mem[rd_ptr_reg];
        end else begin
            rf_write_en_reg   <= 1'b0;
        end
    end

    // One saturating pending counter per register. The decrement lands on the
    // same edge the register file commits, so busy clears only once the new
    // value is readable and operand fetch needs no forwarding path.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            logic inc_hit;
            logic dec_hit;
            assign inc_hit = issue_valid && (issue_reg == ADDR_W'(gi)) &&
                             (pending_reg[gi] != 2'd3);
            assign dec_hit = rf_write_en_reg && (rf_write_addr_reg == ADDR_W'(gi)) &&
                             (pending_reg[gi] != 2'd0);

            // Counter update; increment and decrement together leave it as is.
            always_ff @(posedge clk) begin
                if (rst)
                    pending_reg[gi] <= 2'd0;
                else if (inc_hit && !dec_hit)
                    pending_reg[gi] <= pending_reg[gi] + 2'd1;
                else if (dec_hit && !inc_hit)
                    pending_reg[gi] <= pending_reg[gi] - 2'd1;
            end

            assign busy_mask[gi] = (pending_reg[gi] != 2'd0);
        end
    endgenerate

    assign hazard_stall  = busy_mask[src1_addr] | busy_mask[src2_addr];
    assign issue_full    = (pending_reg[issue_reg] == 2'd3);
    assign in_ready      = in_ready_reg;
    assign rf_write_en   = rf_write_en_reg;
    assign rf_write_addr = rf_write_addr_reg;
    assign rf_write_data = rf_write_data_reg;

endmodule

// File: tb/tb_write_back_unit.sv
// Testbench for write_back_unit: a queue-based reference model tracks the
// result buffer and pending counts, a compare process checks every output on
// every falling edge, and directed literal checks pin the model.
module tb_write_back_unit;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;
    localparam int PC_W     = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_reg;
    logic                issue_full;
    logic [ADDR_W-1:0]   src1_addr;
    logic [ADDR_W-1:0]   src2_addr;
    logic                hazard_stall;
    logic [NUM_REGS-1:0] busy_mask;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_sel;
    logic                in_reg_write;
    logic [ADDR_W-1:0]   in_dest;
    logic [DATA_W-1:0]   in_alu;
    logic [DATA_W-1:0]   in_mem;
    logic [PC_W-1:0]     in_pc;
    logic                rf_hold;
    logic                rf_write_en;
    logic [ADDR_W-1:0]   rf_write_addr;
    logic [DATA_W-1:0]   rf_write_data;

    int checks = 0;
    int errors = 0;

    write_back_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .PC_W(PC_W)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_full(issue_full),
        .src1_addr(src1_addr), .src2_addr(src2_addr), .hazard_stall(hazard_stall),
        .busy_mask(busy_mask),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_reg_write(in_reg_write), .in_dest(in_dest),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc(in_pc),
        .rf_hold(rf_hold),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } result_t;

    result_t           q[$];
    int                pend [NUM_REGS];
    logic              exp_en;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_ready;
    bit                model_on = 0;

    function automatic logic [DATA_W-1:0] pick(input logic [1:0] s);
        if (s == 2'b01)      return in_mem;
        else if (s == 2'b10) return DATA_W'(in_pc);
        else                 return in_alu;
    endfunction

    // Model advances on each rising edge from the inputs held over the cycle.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            foreach (pend[i]) pend[i] = 0;
            exp_en = 0; exp_addr = '0; exp_data = '0; exp_ready = 0;
            model_on = 1;
        end else if (model_on) begin
            bit do_pop, do_push, do_inc, do_dec;
            result_t e;
            do_pop  = (q.size() > 0) && !rf_hold;
            do_push = in_valid && exp_ready;
            do_inc  = issue_valid && pend[issue_reg] != 3;
            do_dec  = exp_en && pend[exp_addr] != 0;
            if (do_inc) pend[issue_reg] = pend[issue_reg] + 1;
            if (do_dec) pend[exp_addr]  = pend[exp_addr] - 1;
            if (do_pop) begin
                e = q.pop_front();
                exp_en = e.rw; exp_addr = e.dest; exp_data = e.data;
            end else begin
                exp_en = 0;
            end
            if (do_push) begin
                e.rw = in_reg_write; e.dest = in_dest; e.data = pick(in_sel);
                q.push_back(e);
            end
            exp_ready = (q.size() < 2);
        end
    end

    // Compare every output against the model midway through each cycle.
    always @(negedge clk) begin
        if (model_on) begin
            logic [NUM_REGS-1:0] exp_busy;
            for (int i = 0; i < NUM_REGS; i++) exp_busy[i] = (pend[i] != 0);
            check("m_write_en", 64'(rf_write_en), 64'(exp_en));
            check("m_write_addr", 64'(rf_write_addr), 64'(exp_addr));
            check("m_write_data", rf_write_data, exp_data);
            check("m_in_ready", 64'(in_ready), 64'(exp_ready));
            check("m_busy_mask", 64'(busy_mask), 64'(exp_busy));
            check("m_hazard", 64'(hazard_stall), 64'(exp_busy[src1_addr] | exp_busy[src2_addr]));
            check("m_issue_full", 64'(issue_full), 64'(pend[issue_reg] == 3));
            if (rf_write_en)
                $display("WRITE r%0d data=%h", rf_write_addr, rf_write_data);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] s, input logic rw, input logic [ADDR_W-1:0] d,
                         input logic [DATA_W-1:0] v);
        in_valid = 1; in_sel = s; in_reg_write = rw; in_dest = d;
        in_alu = v; in_mem = ~v; in_pc = v[PC_W-1:0];
    endtask

    initial begin
        rst = 1; issue_valid = 0; issue_reg = '0; src1_addr = '0; src2_addr = '0;
        in_valid = 0; in_sel = 0; in_reg_write = 0; in_dest = '0;
        in_alu = '0; in_mem = '0; in_pc = '0; rf_hold = 0;

        // Reset held for two edges.
        step(); step();
        @(negedge clk);
        check("rst_write_en", 64'(rf_write_en), 64'd0);
        check("rst_write_addr", 64'(rf_write_addr), 64'd0);
        check("rst_write_data", rf_write_data, 64'd0);
        check("rst_busy_mask", 64'(busy_mask), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_issue_full", 64'(issue_full), 64'd0);
        rst = 0;
        step();
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_busy_mask", 64'(busy_mask), 64'd0);

        // Single ALU write to r5.
        step();
        issue_valid = 1; issue_reg = 4'd5;
        step();
        issue_valid = 0;
        offer(2'b00, 1, 4'd5, 64'h1234);
        @(negedge clk);
        check("alu_busy5_pre", 64'(busy_mask[5]), 64'd1);
        step();                                   // edge k: accepted
        in_valid = 0;
        step();                                   // edge k+1: popped
        @(negedge clk);
        check("alu_write_en", 64'(rf_write_en), 64'd1);
        check("alu_write_addr", 64'(rf_write_addr), 64'd5);
        check("alu_write_data", rf_write_data, 64'h1234);
        check("alu_busy5_mid", 64'(busy_mask[5]), 64'd1);
        step();                                   // edge k+2: committed
        @(negedge clk);
        check("alu_busy5_post", 64'(busy_mask[5]), 64'd0);

        // Hazard detection.
        step();
        issue_valid = 1; issue_reg = 4'd3;
        step();
        issue_valid = 0; src1_addr = 4'd3; src2_addr = 4'd0;
        @(negedge clk);
        check("hazard_set", 64'(hazard_stall), 64'd1);
        step();
        src1_addr = 4'd4; src2_addr = 4'd7;
        @(negedge clk);
        check("hazard_clear", 64'(hazard_stall), 64'd0);

        // Backpressure: third offer refused, then in-order drain.
        step();
        rf_hold = 1;
        offer(2'b00, 1, 4'd6, 64'h11);
        step();
        offer(2'b00, 1, 4'd6, 64'h22);
        step();
        offer(2'b00, 1, 4'd6, 64'h33);
        @(negedge clk);
        check("bp_ready_low", 64'(in_ready), 64'd0);
        step();
        in_valid = 0; rf_hold = 0;
        step();
        @(negedge clk);
        check("bp_first", rf_write_data, 64'h11);
        step();
        @(negedge clk);
        check("bp_second", rf_write_data, 64'h22);
        check("bp_second_en", 64'(rf_write_en), 64'd1);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        @(negedge clk);
        check("bp_third_dropped", 64'(rf_write_en), 64'd0);

        // Source select: PC link, memory, ALU via 11, and a no-write result.
        step();
        offer(2'b10, 1, 4'd1, 64'hFFFF_FFFF_FFFF_FFA7);
        step();
        offer(2'b01, 1, 4'd8, 64'h0123_4567_89AB_CDEF);
        step();
        @(negedge clk);
        check("sel_pc", rf_write_data, 64'h0000_0000_0000_00A7);
        offer(2'b11, 0, 4'd9, 64'h55);
        step();
        in_valid = 0;
        @(negedge clk);
        check("sel_mem", rf_write_data, 64'hFEDC_BA98_7654_3210);
        step();
        @(negedge clk);
        check("no_write_en", 64'(rf_write_en), 64'd0);

        // Counter saturation on r2.
        step();
        issue_valid = 1; issue_reg = 4'd2;
        step(); step(); step();
        @(negedge clk);
        check("full_at_3", 64'(issue_full), 64'd1);
        step();                                   // fourth issue ignored
        issue_valid = 0;
        // Two commits to r2; the second coincides with a new issue.
        offer(2'b00, 1, 4'd2, 64'h2A);
        step();
        offer(2'b00, 1, 4'd2, 64'h2B);
        step();
        in_valid = 0;
        step();                                   // first r2 commit: 3 -> 2
        issue_valid = 1; issue_reg = 4'd2;
        step();                                   // commit + issue: stays 2
        issue_valid = 0;
        @(negedge clk);
        check("simul_not_full", 64'(issue_full), 64'd0);
        check("simul_busy2", 64'(busy_mask[2]), 64'd1);
        step();
        issue_valid = 1;
        step();
        issue_valid = 0;
        @(negedge clk);
        check("simul_then_full", 64'(issue_full), 64'd1);

        // Reset mid-operation.
        step();
        issue_valid = 1; issue_reg = 4'd9;
        step(); step();
        issue_valid = 0; rf_hold = 1;
        offer(2'b00, 1, 4'd9, 64'h99);
        step();
        offer(2'b00, 1, 4'd9, 64'h9A);
        step();
        in_valid = 0;
        @(negedge clk);
        check("mid_busy9", 64'(busy_mask[9]), 64'd1);
        rst = 1; rf_hold = 0;
        step();
        @(negedge clk);
        check("mid_rst_en", 64'(rf_write_en), 64'd0);
        check("mid_rst_busy", 64'(busy_mask), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        rst = 0;
        step(); step(); step();
        @(negedge clk);
        check("mid_after_en", 64'(rf_write_en), 64'd0);
        check("mid_after_ready", 64'(in_ready), 64'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_back_unit.md
Name: write_back_unit

Overview:
- Final pipeline stage, at the opposite end of the register-file interface from operand fetch. Operand fetch reads operands and issues instructions; this block retires results and drives the register file write port.
- Holds a 2-entry result buffer with a valid/ready handshake and selects the write-back data source.
- Keeps a per-register pending-write scoreboard. Operand fetch queries it to stall on read-after-write hazards.

Parameters:
- DATA_W, 64, register data width
- ADDR_W, 4, register address width
- NUM_REGS, 16, number of architectural registers (2^ADDR_W)
- PC_W, 8, program counter width

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  operand fetch issued an instruction that writes issue_reg
- issue_reg  in  ADDR_W  destination of the issued instruction
- issue_full  out  1  pending counter of issue_reg is 3; operand fetch must not issue
- src1_addr  in  ADDR_W  operand-fetch read port 1 address
- src2_addr  in  ADDR_W  operand-fetch read port 2 address
- hazard_stall  out  1  combinational: busy[src1_addr] or busy[src2_addr]
- busy_mask  out  NUM_REGS  bit r set when pending[r] != 0
- in_valid  in  1  result bundle valid
- in_ready  out  1  buffer can accept a result
- in_sel  in  2  data source: 00 ALU, 01 memory, 10 PC link, 11 ALU
- in_reg_write  in  1  result writes a register (clear for SW/branch)
- in_dest  in  ADDR_W  destination register
- in_alu  in  DATA_W  ALU result
- in_mem  in  DATA_W  load data
- in_pc  in  PC_W  PC for link writes
- rf_hold  in  1  register file write port unavailable this cycle
- rf_write_en  out  1  register file write enable (registered)
- rf_write_addr  out  ADDR_W  register file write address (registered)
- rf_write_data  out  DATA_W  register file write data (registered)

Behaviour:
- Reset (rst=1 at posedge): buffer empty, all pending counters 0.
  - During reset: rf_write_en=0, rf_write_addr=0, rf_write_data=0, busy_mask=0, in_ready=0, issue_full=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - Reset mid-operation discards buffered and in-flight results with no register write.
- Buffer: 2-entry FIFO; in_ready = (count<2), registered.
  - Push on in_valid & in_ready.
  - in_valid while in_ready=0 is ignored, not queued.
- Pop: at a posedge with count>0 (count sampled before the edge) and rf_hold=0.
  - A push and a pop at the same edge keep count unchanged.
  - An entry pushed at edge k pops no earlier than edge k+1.
- Write outputs are loaded at every posedge:
  - rf_write_en = pop & head.reg_write.
  - rf_write_addr = head.dest; rf_write_data = selected data.
  - If no pop: rf_write_en=0, addr and data hold their previous values.
- Data select: 00/11 -> in_alu; 01 -> in_mem; 10 -> in_pc zero-extended to DATA_W.
- Minimum latency: accept at edge k, rf_write_en high in the cycle after edge k+1, register file updated at edge k+2.
- Scoreboard: one 2-bit counter pending[r] per register.
  - Increment at a posedge with issue_valid=1 and pending[issue_reg]!=3.
  - Decrement pending[rf_write_addr] at a posedge with rf_write_en=1, i.e. the edge at which the register file commits.
  - Increment and decrement of the same register at the same edge leaves the counter unchanged.
  - Decrement of a counter already at 0 has no effect.
  - Issue while the counter is 3 is ignored; issue_full warns operand fetch in advance.
- busy[r] clears after the commit edge, so operand fetch never reads a stale value and no forwarding is needed.
- Results with in_reg_write=0 occupy a buffer slot and pop, but produce no write and no decrement.
- hazard_stall and issue_full are combinational from the scoreboard and current inputs; busy_mask is a direct decode of the counters.

Test Plan:
- Reset then idle: rst held 2 cycles -> all outputs 0 in reset; in_ready=1, busy_mask=0 afterwards.
- Single ALU write: issue r5, then in_sel=00, in_dest=5, in_alu=0x1234 accepted at edge k.
  - rf_write_en=1, rf_write_addr=5, rf_write_data=0x1234 in the cycle after edge k+1.
  - busy_mask[5] is 1 until after edge k+2, then 0.
- Hazard: pending[3]=1, src1_addr=3 -> hazard_stall=1; src1_addr=4, src2_addr=7 with no pending writes -> hazard_stall=0.
- Backpressure: rf_hold=1, three results offered on consecutive cycles.
  - First two accepted; in_ready=0 and the third is refused.
  - Release rf_hold -> two writes on consecutive cycles, in order; in_ready returns to 1.
- Source select and counters:
  - in_sel=10, in_pc=0xA7 -> rf_write_data=0x00000000000000A7.
  - Three issues to r2 -> issue_full=1 when issue_reg=2; a fourth issue is ignored.
  - Simultaneous issue and commit of r2 -> counter unchanged.
- Reset mid-operation: two entries buffered, pending[9]=2, assert rst -> no further rf_write_en, busy_mask=0, buffer empty.
